// File: rtl/pkt_stream_pkg.sv
// pkt_stream_pkg: state type and default parameters for the packet stream driver.
package pkt_stream_pkg;
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
   localparam int DEF_NUM_PKT   = 10;
   localparam int DEF_NUM_FIELD = 3;
   localparam int DEF_FIELD_W   = 255;
   localparam int DEF_LEN_W     = 32;
endpackage

// File: rtl/pkt_stream_driver_if.sv
// pkt_stream_driver_if: valid/ready beat stream carrying one field per beat.
interface pkt_stream_driver_if import pkt_stream_pkg::*; #(
   parameter int FIELD_W = DEF_FIELD_W
);
   logic               valid;
   logic               ready;
   logic               last;
   logic [FIELD_W-1:0] data;
   modport master (output valid, last, data, input ready);
   modport slave  (input valid, last, data, output ready);
endinterface

// File: rtl/pkt_index_ctr.sv
// pkt_index_ctr: wrapping (packet, field) index pair with a last-field flag.
module pkt_index_ctr #(
   parameter int NUM_PKT   = 10,
   parameter int NUM_FIELD = 3,
   parameter int PW        = 4,
   parameter int FW        = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          clr_i,
   input  logic          adv_i,
   output logic [PW-1:0] p_o,
   output logic [FW-1:0] f_o,
   output logic          last_o
);
   logic [PW-1:0] p_q, p_d;
   logic [FW-1:0] f_q, f_d;
   logic          p_wrap;
   assign last_o = f_q == FW'(NUM_FIELD - 1);
   assign p_wrap = p_q == PW'(NUM_PKT - 1);
   assign p_o    = p_q;
   assign f_o    = f_q;
   always_comb begin
      f_d = clr_i ? '0 : adv_i ? (last_o ? '0 : f_q + FW'(1)) : f_q;
      p_d = clr_i ? '0 : (adv_i && last_o) ? (p_wrap ? '0 : p_q + PW'(1)) : p_q;
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         p_q <= '0;
         f_q <= '0;
      end else begin
         p_q <= p_d;
         f_q <= f_d;
      end
   end
endmodule

// File: rtl/pkt_stream_driver.sv
// pkt_stream_driver: snapshots a packet table on start and streams len beats of it,
// cycling through fields and packets, with a running beat count and XOR checksum.
module pkt_stream_driver import pkt_stream_pkg::*; #(
   parameter int NUM_PKT   = DEF_NUM_PKT,
   parameter int NUM_FIELD = DEF_NUM_FIELD,
   parameter int FIELD_W   = DEF_FIELD_W,
   parameter int LEN_W     = DEF_LEN_W
) (
   input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  logic                                       start_i,
   input  logic                                       abort_i,
   input  logic [LEN_W-1:0]                           len_i,
   input  logic [NUM_PKT-1:0][NUM_FIELD-1:0][FIELD_W-1:0] pkt_i,
   pkt_stream_driver_if.master                        stream_o,
   output logic                                       busy_o,
   output logic                                       done_o,
   output logic [LEN_W-1:0]                           beat_cnt_o,
   output logic [FIELD_W-1:0]                         chk_o
);
   localparam int PW = (NUM_PKT > 1) ? $clog2(NUM_PKT) : 1;
   localparam int FW = (NUM_FIELD > 1) ? $clog2(NUM_FIELD) : 1;
   state_e                                       state_q;
   logic [NUM_PKT-1:0][NUM_FIELD-1:0][FIELD_W-1:0] tbl_q;
   logic [LEN_W-1:0]                             len_q, cnt_q;
   logic [FIELD_W-1:0]                           chk_q, data;
   logic                                         valid_q, busy_q, done_q;
   logic [PW-1:0]                                p;
   logic [FW-1:0]                                f;
   logic                                         last_f, accept, xfer;
   assign accept = (state_q == IDLE) && start_i;
   assign xfer   = valid_q && stream_o.ready;
   // Direct mux off the snapshot; gated so the bus reads zero outside SEND
   assign data   = valid_q ? tbl_q[p][f] : '0;
   pkt_index_ctr #(
      .NUM_PKT(NUM_PKT), .NUM_FIELD(NUM_FIELD), .PW(PW), .FW(FW)
   ) u_idx (
      .clk_i(clk_i), .reset_i(reset_i), .clr_i(accept), .adv_i(xfer),
      .p_o(p), .f_o(f), .last_o(last_f)
   );
   assign stream_o.valid = valid_q;
   assign stream_o.data  = data;
   assign stream_o.last  = valid_q && last_f;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign beat_cnt_o     = cnt_q;
   assign chk_o          = chk_q;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         tbl_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         chk_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               tbl_q   <= pkt_i;
               len_q   <= len_i;
               cnt_q   <= '0;
               chk_q   <= '0;
               busy_q  <= 1'b1;
               valid_q <= len_i != '0;
               done_q  <= len_i == '0;
               state_q <= (len_i == '0) ? DONE : SEND;
            end
            SEND: begin
               if (xfer) begin
                  cnt_q <= cnt_q + LEN_W'(1);
                  chk_q <= chk_q ^ data;
               end
               // Abort wins over completion; a coinciding transfer still counts
               if (abort_i) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (xfer && (cnt_q + LEN_W'(1) == len_q)) begin
                  state_q <= DONE;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pkt_stream_driver.sv
// tb_pkt_stream_driver: directed and randomized checks of pkt_stream_driver against a beat-sequence model.
module tb_pkt_stream_driver;
   localparam int NP = 2, NF = 3, FW = 8, LW = 32, NB = NP * NF, PB = NP * NF * FW;
   logic clk = 1'b0;
   logic reset_i, start_i, abort_i;
   logic [LW-1:0] len_i;
   logic [NP-1:0][NF-1:0][FW-1:0] pkt_i;
   logic busy_o, done_o;
   logic [LW-1:0] beat_cnt_o;
   logic [FW-1:0] chk_o;
   logic [FW-1:0] tbl [NB];
   int n_chk = 0, n_fail = 0;
   pkt_stream_driver_if #(.FIELD_W(FW)) s ();
   pkt_stream_driver #(.NUM_PKT(NP), .NUM_FIELD(NF), .FIELD_W(FW), .LEN_W(LW)) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
      .len_i(len_i), .pkt_i(pkt_i), .stream_o(s), .busy_o(busy_o),
      .done_o(done_o), .beat_cnt_o(beat_cnt_o), .chk_o(chk_o)
   );
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Beat k of a run carries table entry k mod NB, in packet-major order
   task automatic load(input bit rnd);
      for (int i = 0; i < NB; i++) begin
         tbl[i] = rnd ? FW'($urandom) : FW'(i + 1);
         pkt_i[i / NF][i % NF] = tbl[i];
      end
   endtask

   task automatic start_run(input int len);
      len_i = LW'(len);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; len_i = '0; pkt_i = '0; s.ready = 1'b0;
      repeat (2) step();
      n_chk++;
      if ({s.valid, s.last, busy_o, done_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: valid/last/busy/done=%b want 0000", {s.valid, s.last, busy_o, done_o});
      end
      n_chk++;
      if (s.data !== '0 || beat_cnt_o !== '0 || chk_o !== '0) begin
         n_fail++;
         $display("FAIL reset_values: data=%h cnt=%0d chk=%h want 0", s.data, beat_cnt_o, chk_o);
      end
      reset_i = 1'b0;
      step();
      n_chk++;
      if (busy_o !== 1'b0 || s.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b valid=%b want 0", busy_o, s.valid);
      end
   endtask

   task automatic test_seq(input int len, input logic [FW-1:0] exp_chk);
      logic [FW-1:0] x = '0;
      load(1'b0);
      s.ready = 1'b1;
      start_run(len);
      for (int k = 0; k < len; k++) begin
         n_chk++;
         if (s.valid !== 1'b1 || s.data !== tbl[k % NB] || s.last !== (k % NF == NF - 1)) begin
            n_fail++;
            $display("FAIL seq%0d_beat%0d: valid=%b data=%h last=%b want 1 %h %b",
                     len, k, s.valid, s.data, s.last, tbl[k % NB], k % NF == NF - 1);
         end
         x ^= tbl[k % NB];
         step();
      end
      n_chk++;
      if (done_o !== 1'b1 || s.valid !== 1'b0 || beat_cnt_o !== LW'(len) || chk_o !== exp_chk || chk_o !== x) begin
         n_fail++;
         $display("FAIL seq%0d_done: done=%b valid=%b cnt=%0d chk=%h want 1 0 %0d %h", len, done_o, s.valid, beat_cnt_o, chk_o, len, exp_chk);
      end
      step();
      n_chk++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || beat_cnt_o !== LW'(len) || chk_o !== exp_chk) begin
         n_fail++;
         $display("FAIL seq%0d_hold: done=%b busy=%b cnt=%0d chk=%h want 0 0 %0d %h", len, done_o, busy_o, beat_cnt_o, chk_o, len, exp_chk);
      end
   endtask

   task automatic test_stall();
      int k = 0, stall = 0, cyc = 0;
      load(1'b0);
      start_run(6);
      while (k < 6 && cyc < 50) begin
         n_chk++;
         if (s.valid !== 1'b1 || s.data !== tbl[k]) begin
            n_fail++;
            $display("FAIL stall_beat%0d_c%0d: valid=%b data=%h want 1 %h", k, cyc, s.valid, s.data, tbl[k]);
         end
         s.ready = !(k == 1 && stall < 3);
         if (s.ready) k++;
         else stall++;
         cyc++;
         step();
      end
      s.ready = 1'b1;
      n_chk++;
      if (done_o !== 1'b1 || chk_o !== 8'h07 || beat_cnt_o !== 6 || stall != 3) begin
         n_fail++;
         $display("FAIL stall_done: done=%b chk=%h cnt=%0d stalls=%0d want 1 07 6 3", done_o, chk_o, beat_cnt_o, stall);
      end
      step();
   endtask

   task automatic test_abort();
      load(1'b0);
      s.ready = 1'b1;
      start_run(6);
      repeat (3) step();
      n_chk++;
      if (s.data !== tbl[3] || s.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: data=%h valid=%b want %h 1", s.data, s.valid, tbl[3]);
      end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      n_chk++;
      if (s.valid !== 1'b0 || busy_o !== 1'b0 || beat_cnt_o !== 4 || chk_o !== 8'h04 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_post: valid=%b busy=%b cnt=%0d chk=%h done=%b want 0 0 4 04 0", s.valid, busy_o, beat_cnt_o, chk_o, done_o);
      end
      step();
      n_chk++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_nodone: done=%b busy=%b want 0 0", done_o, busy_o);
      end
   endtask

   task automatic test_reset_midrun();
      load(1'b0);
      s.ready = 1'b1;
      start_run(6);
      step();
      #2;
      reset_i = 1'b1;
      #1;
      n_chk++;
      if (s.valid !== 1'b0 || busy_o !== 1'b0 || s.data !== '0) begin
         n_fail++;
         $display("FAIL reset_async: valid=%b busy=%b data=%h want 0 0 00", s.valid, busy_o, s.data);
      end
      step();
      reset_i = 1'b0;
      step();
      n_chk++;
      if (busy_o !== 1'b0 || s.valid !== 1'b0 || beat_cnt_o !== '0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%b valid=%b cnt=%0d want 0 0 0", busy_o, s.valid, beat_cnt_o);
      end
      start_run(0);
      n_chk++;
      if (done_o !== 1'b1 || s.valid !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_done: done=%b valid=%b busy=%b want 1 0 1", done_o, s.valid, busy_o);
      end
      step();
      n_chk++;
      if (done_o !== 1'b0 || s.valid !== 1'b0 || busy_o !== 1'b0 || chk_o !== '0) begin
         n_fail++;
         $display("FAIL len0_idle: done=%b valid=%b busy=%b chk=%h want 0 0 0 00", done_o, s.valid, busy_o, chk_o);
      end
   endtask

   // Random tables, lengths, backpressure and aborts; start/len/pkt scrambled mid-run
   task automatic test_random();
      for (int run = 0; run < 25; run++) begin
         int len, ab, k, cyc;
         bit r, a_now, aborted;
         logic [FW-1:0] x;
         load(1'b1);
         len = $urandom_range(0, 15);
         ab = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         k = 0; cyc = 0; x = '0; aborted = 1'b0;
         s.ready = 1'b1;
         start_run(len);
         while (k < len && !aborted && cyc < 200) begin
            n_chk++;
            if (s.valid !== 1'b1 || s.data !== tbl[k % NB] || s.last !== (k % NF == NF - 1)) begin
               n_fail++;
               $display("FAIL rnd%0d_beat%0d: valid=%b data=%h last=%b want 1 %h %b",
                        run, k, s.valid, s.data, s.last, tbl[k % NB], k % NF == NF - 1);
            end
            r = $urandom_range(0, 99) < 70;
            a_now = (k == ab) && $urandom_range(0, 1) == 1;
            s.ready = r;
            abort_i = a_now;
            start_i = $urandom_range(0, 1) == 1;
            len_i = $urandom;
            pkt_i = PB'({$urandom, $urandom});
            step();
            if (r) begin
               x ^= tbl[k % NB];
               k++;
            end
            if (a_now) aborted = 1'b1;
            cyc++;
         end
         start_i = 1'b0; abort_i = 1'b0; s.ready = 1'b1;
         n_chk++;
         if (cyc >= 200) begin
            n_fail++;
            $display("FAIL rnd%0d_timeout: beats=%0d want %0d", run, k, len);
         end
         n_chk++;
         if (aborted ? (done_o !== 1'b0 || busy_o !== 1'b0 || s.valid !== 1'b0)
                     : (done_o !== 1'b1 || busy_o !== 1'b1 || s.valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL rnd%0d_end: done=%b busy=%b valid=%b aborted=%b", run, done_o, busy_o, s.valid, aborted);
         end
         n_chk++;
         if (beat_cnt_o !== LW'(k) || chk_o !== x) begin
            n_fail++;
            $display("FAIL rnd%0d_sum: cnt=%0d chk=%h want %0d %h", run, beat_cnt_o, chk_o, k, x);
         end
         step();
         n_chk++;
         if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_idle: busy=%b done=%b want 0 0", run, busy_o, done_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_seq(6, 8'h07);
      test_seq(8, 8'h04);
      test_stall();
      test_abort();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pkt_stream_driver.md
PKT_STREAM_DRIVER -- requirements
Module: pkt_stream_driver

Interface
REQ-001 Parameters SHALL be:
- NUM_PKT, default 10, packets in the table.
- NUM_FIELD, default 3, fields per packet.
- FIELD_W, default 255, bits per field.
- LEN_W, default 32, width of the beat-count input.
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a run; honoured only in IDLE.
- abort_i  in  1  terminate a run in progress.
- len_i  in  LEN_W  total beats to send; sampled at accepted start.
- pkt_i  in  [NUM_PKT][NUM_FIELD][FIELD_W] packed  packet table.
- valid_o  out  1  beat valid.
- ready_i  in  1  sink accepts beat.
- data_o  out  FIELD_W  current field.
- last_o  out  1  current beat is the final field of a packet.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle completion pulse.
- beat_cnt_o  out  LEN_W  beats transferred this run.
- chk_o  out  FIELD_W  XOR of all transferred beats this run.

Function
REQ-003 The FSM SHALL have states IDLE, SEND and DONE.
REQ-004 In IDLE with start_i=1, the block SHALL, on that edge:
- snapshot pkt_i into an internal buffer;
- latch len_i;
- clear beat_cnt_o, chk_o and the indices;
- enter SEND, or DONE if len_i==0.
REQ-005 In SEND, valid_o SHALL be 1, data_o SHALL be buf[p][f], and last_o SHALL be (f==NUM_FIELD-1).
REQ-006 A transfer SHALL occur on each edge where valid_o&&ready_i.
REQ-007 While valid_o&&!ready_i, data_o, last_o and the indices SHALL hold.
REQ-008 On each transfer, f SHALL increment, wrapping to 0 at NUM_FIELD-1. p SHALL increment on that field wrap, wrapping to 0 at NUM_PKT-1.
REQ-009 On each transfer, beat_cnt_o SHALL increment and chk_o SHALL update as chk_o^data_o.
REQ-010 The transfer that makes beat_cnt_o equal the latched length SHALL move the FSM to DONE. valid_o SHALL be 0 from the following cycle.
REQ-011 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE. beat_cnt_o and chk_o SHALL hold until the next accepted start.
REQ-012 busy_o SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-013 start_i outside IDLE SHALL be ignored.
REQ-014 Changes on pkt_i or len_i after an accepted start SHALL not affect the run.
REQ-015 abort_i in SEND SHALL return the FSM to IDLE on that edge with no done_o pulse. If abort_i coincides with a transfer, the beat SHALL count.
REQ-016 abort_i SHALL take priority over completion when both occur on the same edge.
REQ-017 abort_i SHALL be ignored in IDLE and DONE.
REQ-018 Latency SHALL be: first valid_o in the cycle after an accepted start; done_o in the cycle after the final transfer.

Reset
REQ-019 reset_i=1 SHALL asynchronously force:
- FSM to IDLE;
- all outputs to 0;
- indices, latched length and internal buffer to 0.
REQ-020 Reset mid-run SHALL discard the run entirely. The first cycle after release SHALL be IDLE.

Structure
REQ-021 Package pkt_stream_pkg SHALL hold the state enum and the default parameter constants.
REQ-022 Sub-module pkt_index_ctr SHALL implement the wrapping (p,f) counter pair and last-field flag, with inputs clr and adv.
REQ-023 The buffer read SHALL be a combinational mux indexed by (p,f) with no added pipeline stage.

Verification (config NUM_PKT=2, NUM_FIELD=3, FIELD_W=8; table fields in order 01..06)
REQ-024 ready_i=1, len_i=6, start -> data_o 01..06 on six consecutive cycles, last_o on beats 3 and 6, done_o the next cycle, chk_o=07, beat_cnt_o=6.
REQ-025 ready_i=1, len_i=8 -> beats 7 and 8 are 01 and 02 (wrap), last_o only on beats 3 and 6, chk_o=04.
REQ-026 len_i=6, ready_i low for 3 cycles while 02 presented -> data_o holds 02 and valid_o holds 1; sequence completes with chk_o=07.
REQ-027 len_i=6, abort_i with beat 4 transferring -> valid_o=0 next cycle, busy_o=0, beat_cnt_o=4, chk_o=04, no done_o.
REQ-028 reset_i asserted mid-SEND (between edges) -> valid_o, busy_o and data_o go 0 immediately; a later start with len_i=0 -> done_o one cycle after start and valid_o never 1.
